spi_gpio_bridge: RTL and testbench
==================================

# spi_gpio_bridge

User design for the fabric's 32-pin IO ring: an SPI slave on pins 0-3 that lets an external host set output values and output enables of pins 4-31 and read back their input levels. It is the logic that sits behind the IO cells and the global clock inside the fabric. SPI signals are oversampled in the fabric `clk` domain, so there is no second clock.

## Interface
Parameters:
- `NUM_IO`, 32: width of the pin vectors; pins 0-3 are reserved for SPI, `NUM_IO-4` pins are GPIO.
- `HB_BIT`, 23: heartbeat counter bit used only when `SPI_GPIO_HEARTBEAT_EN` is defined.

Ports:
- `clk`  in  1  fabric global clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `io_in`  in  NUM_IO  pad inputs. [0]=SCLK, [1]=CS_N, [2]=MOSI.
- `io_out`  out  NUM_IO  pad outputs. [3]=MISO.
- `io_oeb`  out  NUM_IO  output-enable bar per pin; 1 = input/tristate.

## Operation
- SCLK, CS_N and MOSI each pass through a 2-flop synchronizer followed by an edge-detect register. CS_N synchronizes to 1 at reset.
- SPI mode 0, MSB first:
  - MOSI is sampled on the synchronized SCLK rising edge.
  - MISO changes on the falling edge.
- Frame layout is 40 bits:
  - Command byte: bit7 = W (1 = write), bits[6:2] ignored, bits[1:0] = ADDR.
  - Then 32 data bits.
- Registers:
  - ADDR 0 OUT (RW): bits[31:4] drive `io_out[31:4]`.
  - ADDR 1 OE (RW): 1 = drive; `io_oeb[31:4] = ~OE[31:4]`.
  - ADDR 2 IN (RO): snapshot of synchronized `io_in[31:4]`.
  - ADDR 3 ID (RO): constant 32'h4845_4943.
  - Bits [3:0] are ignored on write and read as 0. Writes to ADDR 2/3 are discarded.
- FSM:
  - IDLE: on CS_N falling edge → CMD, with bit counter cleared.
  - CMD: after 8 rising edges, latch W/ADDR and load the read shift register with the addressed register value (IN is snapshot here) → DATA.
  - DATA: after 32 rising edges → DONE. On a write, the whole 32-bit word commits to OUT/OE in the same cycle as the 32nd rising edge.
  - DONE: further SCLK activity is ignored until CS_N rises → IDLE.
  - In any state, CS_N rising → IDLE immediately. No partial write ever commits.
- MISO:
  - `io_out[3]` = shift-register MSB.
  - The shift register shifts left on each falling edge in DATA, but only once at least one data bit has been received.
  - On a write frame, MISO returns the old register value.
- Fixed pin control:
  - `io_oeb[3]` = synchronized CS_N, so MISO is tristated while deselected.
  - `io_oeb[2:0]` = 1 and `io_out[2:0]` = 0.
- Reset values:
  - OUT = 0, OE = 0.
  - `io_out` = all 0; `io_oeb` = all 1.
  - FSM = IDLE, counters = 0.

## Timing
- Input latency: 3 `clk` cycles from pad to edge pulse.
- SCLK high and low phases must each be ≥ 4 `clk` cycles. CS_N setup/hold to the first/last SCLK edge must be ≥ 4 cycles.
- MISO is valid ≤ 4 `clk` after the synchronized falling edge.
- Register writes reach the pins 1 cycle after commit.
- Reset mid-frame aborts the frame. After `rst_n` rises, the next frame requires a fresh CS_N falling edge.

## Configuration
- `SPI_GPIO_HEARTBEAT_EN` defined:
  - A 32-bit free-running counter is compiled in.
  - `io_out[31]` = counter[`HB_BIT`] and `io_oeb[31]` = 0, regardless of OUT/OE.
  - OUT/OE bit 31 still store and read back.
- Not defined: no counter; pin 31 is an ordinary GPIO.

## Structure
- Package `spi_gpio_pkg` holds:
  - register address localparams (ADDR_OUT/OE/IN/ID),
  - the ID constant,
  - the FSM state enum (IDLE, CMD, DATA, DONE),
  - frame length constants (8, 32).
- Sub-module `spi_pin_sync`: 2-flop synchronizer plus rise/fall pulse outputs, instantiated three times (SCLK, CS_N, MOSI). The MOSI instance uses only its level output.

## Test plan
- Reset → `io_oeb` = 32'hFFFF_FFFF, `io_out` = 0, MISO tristated.
- Read ADDR 3 → host shifts in 32'h4845_4943 on MISO.
- Write OE = 32'h0000_00F0, then OUT = 32'hA5A5_A5A0 → `io_oeb[7:4]` = 0 and `io_out[7:4]` = 4'hA; read back OE = 32'h0000_00F0.
- Drive `io_in[31:4]` = 28'h123_4567, read ADDR 2 → 32'h1234_5670.
- Write OUT with CS_N raised after 20 data bits → OUT unchanged, FSM back to IDLE; the next full frame succeeds.
- With `SPI_GPIO_HEARTBEAT_EN` and `HB_BIT` = 3 → `io_out[31]` toggles every 8 `clk` and `io_oeb[31]` = 0 while OE = 0.

Source files
------------

// File: rtl/spi_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_gpio_pkg
// Description : Shared constants and types for the SPI-to-GPIO bridge:
//               register addresses, ID word, frame lengths, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_gpio_pkg;

    // Register map (2-bit address carried in the command byte)
    localparam logic [1:0]  ADDR_OUT = 2'd0;
    localparam logic [1:0]  ADDR_OE  = 2'd1;
    localparam logic [1:0]  ADDR_IN  = 2'd2;
    localparam logic [1:0]  ADDR_ID  = 2'd3;

    // Read-only identification word
    localparam logic [31:0] ID_VALUE = 32'h4845_4943;

    // Writable GPIO bits; the low four pins are owned by the SPI port
    localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFF0;

    // Frame layout: one command byte followed by one data word
    localparam int CMD_BITS  = 8;
    localparam int DATA_BITS = 32;

    // Frame FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Two-flop synchronizer for one pad input followed by an
//               edge-detect register. Rise/fall pulses are registered, so a
//               pad transition shows up as a pulse three clk cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Synchronize the pad and register single-cycle edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_gpio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_gpio_bridge
// Description : SPI mode-0 slave on pins 0-3 giving an external host access
//               to OUT/OE/IN/ID registers controlling GPIO pins 4..NUM_IO-1.
//               Optional feature macro: SPI_GPIO_HEARTBEAT_EN (drives the top
//               pin from a free-running counter bit HB_BIT).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_gpio_bridge #(
    parameter int NUM_IO = 32,
    parameter int HB_BIT = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb
);
    import spi_gpio_pkg::*;

    // Synchronized SPI pins
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl,   w_cs_rise,   w_cs_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_pin(io_in[0]),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_pin(io_in[1]),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_pin(io_in[2]),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spi_state_t          r_state;
    spi_state_t          w_state_next;
    logic [4:0]          r_bit_cnt;
    logic [6:0]          r_cmd;
    logic [30:0]         r_data;
    logic                r_wr;
    logic [1:0]          r_addr;
    logic                r_rx_any;
    logic [31:0]         r_miso_sr;
    logic [31:0]         r_out;
    logic [31:0]         r_oe;
    logic [NUM_IO-1:4]   r_in_meta;
    logic [NUM_IO-1:4]   r_in_sync;
    logic [1:0]          r_settle;
    logic                r_cs_armed;

    logic                w_cmd_last;
    logic                w_data_last;
    logic [1:0]          w_cmd_addr;
    logic [31:0]         w_word;
    logic [31:0]         w_rd_value;

    assign w_cmd_last  = (r_state == CMD)  && w_sclk_rise && (r_bit_cnt == 5'(CMD_BITS - 1));
    assign w_data_last = (r_state == DATA) && w_sclk_rise && (r_bit_cnt == 5'(DATA_BITS - 1));
    assign w_cmd_addr  = {r_cmd[0], w_mosi_lvl};
    assign w_word      = {r_data, w_mosi_lvl};

    // Value presented on MISO for the addressed register; IN is snapshotted here
    always_comb begin
        w_rd_value = ID_VALUE;
        case (w_cmd_addr)
            ADDR_OUT: w_rd_value = r_out;
            ADDR_OE:  w_rd_value = r_oe;
            ADDR_IN:  w_rd_value = 32'({r_in_sync, 4'b0000});
            default:  w_rd_value = ID_VALUE;
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame FSM next state; CS_N deassertion aborts from any state
    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cs_fall && r_cs_armed) w_state_next = CMD;
                CMD:     if (w_cmd_last)              w_state_next = DATA;
                DATA:    if (w_data_last)             w_state_next = DONE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Shifting, command latch, register commit and CS_N arming after reset.
    // A frame only starts once CS_N has been seen high from the pad, so a
    // frame interrupted by reset cannot resume without a fresh CS_N fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_cmd      <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_rx_any   <= 1'b0;
            r_miso_sr  <= '0;
            r_out      <= '0;
            r_oe       <= '0;
            r_in_meta  <= '0;
            r_in_sync  <= '0;
            r_settle   <= '0;
            r_cs_armed <= 1'b0;
        end else begin
            r_in_meta <= io_in[NUM_IO-1:4];
            r_in_sync <= r_in_meta;

            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end else if (w_cs_lvl) begin
                r_cs_armed <= 1'b1;
            end

            if (w_cs_rise) begin
                r_bit_cnt <= '0;
                r_rx_any  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_bit_cnt <= '0;
                        r_rx_any  <= 1'b0;
                    end
                    CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd <= {r_cmd[5:0], w_mosi_lvl};
                            if (w_cmd_last) begin
                                r_bit_cnt <= '0;
                                r_wr      <= r_cmd[6];
                                r_addr    <= w_cmd_addr;
                                r_miso_sr <= w_rd_value;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (w_sclk_rise) begin
                            r_data    <= {r_data[29:0], w_mosi_lvl};
                            r_rx_any  <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (w_data_last && r_wr) begin
                                if (r_addr == ADDR_OUT) r_out <= w_word & GPIO_MASK;
                                if (r_addr == ADDR_OE)  r_oe  <= w_word & GPIO_MASK;
                            end
                        end else if (w_sclk_fall && r_rx_any) begin
                            r_miso_sr <= {r_miso_sr[30:0], 1'b0};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SPI_GPIO_HEARTBEAT_EN
    logic [31:0] r_hb;

    // Free-running heartbeat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb <= '0;
        end else begin
            r_hb <= r_hb + 32'd1;
        end
    end
`else
    localparam int c_unused_hb_bit = HB_BIT;
`endif

    // Pad outputs: GPIO from OUT/OE, MISO tristated while deselected
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        io_out[NUM_IO-1:4] = r_out[NUM_IO-1:4];
        io_oeb[NUM_IO-1:4] = ~r_oe[NUM_IO-1:4];
        io_out[3]          = r_miso_sr[31];
        io_oeb[3]          = w_cs_lvl;
`ifdef SPI_GPIO_HEARTBEAT_EN
        io_out[NUM_IO-1]   = r_hb[HB_BIT];
        io_oeb[NUM_IO-1]   = 1'b0;
`endif
    end

    // Inputs with no consumer in this design
    logic w_unused_inputs;
    assign w_unused_inputs = ^{io_in[3], w_sclk_lvl, w_mosi_rise, w_mosi_fall};

endmodule
`default_nettype wire

// File: tb/tb_spi_gpio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_gpio_bridge
// Description : Self-checking bench for spi_gpio_bridge: directed table of
//               frames, abort and reset corner cases, then random frames
//               checked against a register-level model.
//               Honours SPI_GPIO_HEARTBEAT_EN (pin 31 expectations).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_gpio_bridge;

    localparam int          PH   = 10;
    localparam logic [31:0] ID_C = 32'h4845_4943;
`ifdef SPI_GPIO_HEARTBEAT_EN
    localparam logic [31:0] PIN_MASK = 32'h7FFF_FFF0;
    localparam logic [31:0] ALL_MASK = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] PIN_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] ALL_MASK = 32'hFFFF_FFFF;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk  = 1'b0;
    logic        cs_n  = 1'b1;
    logic        mosi  = 1'b0;
    logic [27:0] gpio  = '0;
    logic [31:0] io_in;
    logic [31:0] io_out;
    logic [31:0] io_oeb;

    assign io_in = {gpio, 1'b0, mosi, cs_n, sclk};

    always #5 clk = ~clk;

    spi_gpio_bridge #(.NUM_IO(32), .HB_BIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Register-level model state
    logic [31:0] m_out = '0;
    logic [31:0] m_oe  = '0;

    typedef struct {
        bit        w;
        bit [1:0]  addr;
        bit [31:0] data;
        bit [27:0] gpio;
        bit [31:0] exp_rx;
        bit [31:0] exp_out;
        bit [31:0] exp_oe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] m_read(input bit [1:0] a);
        case (a)
            2'd0:    return m_out;
            2'd1:    return m_oe;
            2'd2:    return {gpio, 4'h0};
            default: return ID_C;
        endcase
    endfunction

    task automatic m_write(input bit [1:0] a, input bit [31:0] d);
        if (a == 2'd0) m_out = {d[31:4], 4'h0};
        if (a == 2'd1) m_oe  = {d[31:4], 4'h0};
    endtask

    // Host side of mode 0: MOSI set while SCLK low, MISO sampled before rise
    task automatic shift_bits(input bit [39:0] bits, input int n, output bit [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[39-i];
            wait_clk(PH);
            if (i >= 8) rx = {rx[30:0], io_out[3]};
            sclk = 1'b1;
            wait_clk(PH);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input bit w, input bit [1:0] addr, input bit [4:0] ign,
                             input bit [31:0] data, input int nbits, output bit [31:0] rx);
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(PH);
        shift_bits({w, ign, addr, data}, 8 + nbits, rx);
        wait_clk(PH);
        cs_n = 1'b1;
        wait_clk(PH);
    endtask

    task automatic check_pins(input string tag, input logic [31:0] e_out, input logic [31:0] e_oe);
        check({tag, "_out"},   io_out & PIN_MASK, e_out & PIN_MASK);
        check({tag, "_oeb"},   io_oeb & PIN_MASK, ~e_oe & PIN_MASK);
        check({tag, "_fixed"}, 32'({io_oeb[3:0], io_out[2:0]}), 32'h78);
    endtask

    vec_t        tbl [12];
    bit   [31:0] rx;
    bit   [31:0] exp_rx;
    bit          rw;
    bit   [1:0]  ra;
    bit   [31:0] rd;
    int          nb;
    logic        hb_v0;
    int          hb_t;

    initial begin
        tbl[0]  = '{0, 2'd3, 32'h0,         28'h0,       ID_C,          32'h0,         32'h0};
        tbl[1]  = '{1, 2'd1, 32'h0000_00F0, 28'h0,       32'h0,         32'h0,         32'h0000_00F0};
        tbl[2]  = '{1, 2'd0, 32'hA5A5_A5A0, 28'h0,       32'h0,         32'hA5A5_A5A0, 32'h0000_00F0};
        tbl[3]  = '{0, 2'd1, 32'h0,         28'h0,       32'h0000_00F0, 32'hA5A5_A5A0, 32'h0000_00F0};
        tbl[4]  = '{0, 2'd0, 32'h0,         28'h0,       32'hA5A5_A5A0, 32'hA5A5_A5A0, 32'h0000_00F0};
        tbl[5]  = '{0, 2'd2, 32'h0,         28'h1234567, 32'h1234_5670, 32'hA5A5_A5A0, 32'h0000_00F0};
        tbl[6]  = '{1, 2'd0, 32'h1234_5678, 28'h0,       32'hA5A5_A5A0, 32'h1234_5670, 32'h0000_00F0};
        tbl[7]  = '{0, 2'd0, 32'h0,         28'h0,       32'h1234_5670, 32'h1234_5670, 32'h0000_00F0};
        tbl[8]  = '{1, 2'd3, 32'hFFFF_FFFF, 28'h0,       ID_C,          32'h1234_5670, 32'h0000_00F0};
        tbl[9]  = '{1, 2'd2, 32'h0,         28'h0ABCDEF, 32'h0ABC_DEF0, 32'h1234_5670, 32'h0000_00F0};
        tbl[10] = '{0, 2'd3, 32'h0,         28'h0,       ID_C,          32'h1234_5670, 32'h0000_00F0};
        tbl[11] = '{1, 2'd1, 32'hFFFF_FFFF, 28'h0,       32'h0000_00F0, 32'h1234_5670, 32'hFFFF_FFF0};

        // Reset state
        wait_clk(3);
        check("reset_out", io_out & ALL_MASK, 32'h0);
        check("reset_oeb", io_oeb & ALL_MASK, ALL_MASK);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(PH);
        check("idle_miso_tristate", 32'(io_oeb[3]), 32'h1);

        // Directed frames
        for (int i = 0; i < 12; i++) begin
            gpio = tbl[i].gpio;
            spi_frame(tbl[i].w, tbl[i].addr, 5'b10101, tbl[i].data, 32, rx);
            check($sformatf("tbl%0d_miso", i), rx, tbl[i].exp_rx);
            if (tbl[i].w) m_write(tbl[i].addr, tbl[i].data);
            check_pins($sformatf("tbl%0d", i), tbl[i].exp_out, tbl[i].exp_oe);
        end

        // Aborted write after 20 data bits leaves OUT alone
        gpio = '0;
        spi_frame(1'b1, 2'd0, 5'd0, 32'hFFFF_FFF0, 20, rx);
        check_pins("abort", 32'h1234_5670, 32'hFFFF_FFF0);
        spi_frame(1'b0, 2'd0, 5'd0, 32'h0, 32, rx);
        check("abort_readback", rx, 32'h1234_5670);
        spi_frame(1'b1, 2'd0, 5'd0, 32'h0F0F_0F0F, 32, rx);
        m_write(2'd0, 32'h0F0F_0F0F);
        check_pins("after_abort", 32'h0F0F_0F00, 32'hFFFF_FFF0);

        // Reset mid-frame, then a full frame without a fresh CS_N fall
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(PH);
        shift_bits({1'b1, 7'd0, 32'hFFFF_FFF0}, 18, rx);
        rst_n = 1'b0;
        wait_clk(3);
        check("midreset_out", io_out & ALL_MASK, 32'h0);
        check("midreset_oeb", io_oeb & ALL_MASK, ALL_MASK);
        rst_n = 1'b1;
        m_out = '0;
        m_oe  = '0;
        wait_clk(PH);
        shift_bits({1'b1, 7'd0, 32'hFFFF_FFF0}, 40, rx);
        wait_clk(PH);
        cs_n = 1'b1;
        wait_clk(PH);
        check("no_frame_after_reset", io_out & PIN_MASK, 32'h0);
        spi_frame(1'b1, 2'd0, 5'd0, 32'hCAFE_BAB0, 32, rx);
        m_write(2'd0, 32'hCAFE_BAB0);
        check_pins("fresh_frame", 32'hCAFE_BAB0, 32'h0);

        // Random frames against the model
        for (int i = 0; i < 16; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 2'($urandom_range(0, 3));
            rd   = $urandom;
            gpio = 28'($urandom);
            nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            exp_rx = m_read(ra) >> (32 - nb);
            spi_frame(rw, ra, 5'($urandom), rd, nb, rx);
            check($sformatf("rnd%0d_miso", i), rx, exp_rx);
            if (rw && nb == 32) m_write(ra, rd);
            check_pins($sformatf("rnd%0d", i), m_out, m_oe);
        end

`ifdef SPI_GPIO_HEARTBEAT_EN
        // Heartbeat on pin 31 with HB_BIT = 3: half period of 8 clk
        hb_v0 = io_out[31];
        hb_t  = 0;
        while (io_out[31] == hb_v0 && hb_t < 20) begin
            @(negedge clk);
            hb_t++;
        end
        hb_v0 = io_out[31];
        hb_t  = 0;
        while (io_out[31] == hb_v0 && hb_t < 20) begin
            @(negedge clk);
            hb_t++;
        end
        check("hb_half_period", 32'(hb_t), 32'd8);
        check("hb_oeb", 32'(io_oeb[31]), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
